io_output_fifo: RTL

- Parametrised byte-stream output buffer between the Hubris store path and the external IO drain port.
- Accepts 1-4 byte little-endian writes per cycle into a byte-wide circular FIFO.
- Exposes show-ahead read data, occupancy, a selectable full policy (stall or drop) and overflow diagnostics.

---
 rtl/io_output_fifo.sv | 88 ++++++++
 1 files changed

// File: rtl/io_output_fifo.sv
// Byte-wide circular output buffer between the store path and the IO drain port.
// Accepts 1-4 little-endian bytes per cycle; show-ahead read with stall or drop full policy.
module io_output_fifo #(
   parameter int DEPTH        = 16,
   parameter bit DROP_ON_FULL = 1'b0,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [31:0]          wr_data,
   input  logic [2:0]           wr_bytes,
   input  logic                 io_output_en,
   output logic [7:0]           io_output_data,
   output logic [CNT_WIDTH-1:0] io_buffer_size_avai,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] drop_count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic [AW:0]   free;
   logic [AW:0]   push_amt;
   logic [AW:0]   count_next;
   logic          legal;
   logic          fits;
   logic          do_push;
   logic          do_pop;
   logic          do_drop;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      free       = (AW+1)'(DEPTH) - count;
      legal      = (wr_bytes != 3'd0) && (wr_bytes <= 3'd4);
      fits       = free >= (AW+1)'(wr_bytes);
      do_push    = wr_valid && legal && fits && !clear;
      do_drop    = DROP_ON_FULL && wr_valid && legal && !fits && !clear;
      do_pop     = io_output_en && (count != '0) && !clear;
      push_amt   = do_push ? (AW+1)'(wr_bytes) : '0;
      count_next = count + push_amt - (AW+1)'(do_pop);
      wr_ready   = reset_n && (DROP_ON_FULL ? 1'b1 : fits);
   end

   // Free space is judged on the start-of-cycle count, so a same-cycle pop never makes room.
   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (do_push) tail <= tail + AW'(wr_bytes);
         if (do_pop)  head <= head + AW'(1);
         count <= count_next;
         if (do_drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
         end
      end
   end

   // NOTE: the byte array is left unreset; count gates every read, so stale contents never leak.
   always_ff @(posedge clk) begin
      if (do_push) begin
         for (int k = 0; k < 4; k++) begin
            if (k < int'(wr_bytes)) mem[tail + AW'(k)] <= wr_data[8*k +: 8];
         end
      end
   end

   assign io_output_data      = (count != '0) ? mem[head] : 8'h00;
   assign io_buffer_size_avai = CNT_WIDTH'(count);

endmodule
